// File: rtl/dmem_ctrl_if.sv
// CPU-side load/store request bus plus the byte-serial Dmemory control bus.
// slave = controller view, master = CPU/memory (testbench) view.
interface dmem_ctrl_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_start;
    logic        mem_wea;
    logic [2:0]  mem_rol;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_busy;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, op, addr, wdata, mem_busy, mem_rdata,
        output stall, done, rdata, fault, fault_cause,
               mem_start, mem_wea, mem_rol, mem_addr, mem_wdata
    );

    modport master (
        output req, op, addr, wdata, mem_busy, mem_rdata,
        input  stall, done, rdata, fault, fault_cause,
               mem_start, mem_wea, mem_rol, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Load/store sequencer: checks alignment/range, drives Dmemory, stalls the CPU until busy drops.
// Latency: ISSUE + >=2 WAIT cycles + DONE; faults finish in one cycle; watchdog aborts after TIMEOUT WAIT cycles.
module dmem_ctrl #(
    parameter int ADDR_BITS = 11,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    dmem_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         cause_q, cause_d;

    logic               in_half, in_word, misalign, out_of_range, active;
    logic [2:0]         rol;
    logic [31:0]        load_ext;

    function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] d);
        case (op)
            OP_LB:   extend = {{24{d[7]}}, d[7:0]};
            OP_LBU:  extend = {24'h0, d[7:0]};
            OP_LH:   extend = {{16{d[15]}}, d[15:0]};
            OP_LHU:  extend = {16'h0, d[15:0]};
            OP_LW:   extend = d;
            default: extend = 32'h0;
        endcase
    endfunction

    // Checks run on the incoming request, which is what gets latched on acceptance.
    assign in_half      = (bus.op == OP_LH) || (bus.op == OP_LHU) || (bus.op == OP_SH);
    assign in_word      = (bus.op == OP_LW) || (bus.op == OP_SW);
    assign misalign     = (in_half && bus.addr[0]) || (in_word && (bus.addr[1:0] != 2'b00));
    assign out_of_range = (bus.addr >> ADDR_BITS) != 32'h0;
    assign load_ext     = extend(op_q, bus.mem_rdata);

    always_comb begin
        case (op_q)
            OP_LH, OP_LHU, OP_SH: rol = 3'd2;
            OP_LW, OP_SW:         rol = 3'd4;
            default:              rol = 3'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    op_d    = bus.op;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (misalign) begin
                        cause_d = 2'b01;
                        rdata_d = 32'h0;
                        state_d = S_ERR;
                    end else if (out_of_range) begin
                        cause_d = 2'b10;
                        rdata_d = 32'h0;
                        state_d = S_ERR;
                    end else begin
                        cause_d = 2'b00;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // First WAIT cycle ignores busy: Dmemory may raise it a cycle late.
                if ((cnt_q != '0) && !bus.mem_busy) begin
                    rdata_d = load_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cause_d = 2'b11;
                    rdata_d = 32'h0;
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            cause_q <= cause_d;
        end
    end

    assign active          = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.mem_start   = (state_q == S_ISSUE);
    assign bus.mem_wea     = active && ((op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW));
    assign bus.mem_rol     = active ? rol : 3'd0;
    assign bus.mem_addr    = active ? addr_q : 32'h0;
    assign bus.mem_wdata   = active ? wdata_q : 32'h0;
    assign bus.stall       = bus.req && (state_q != S_DONE) && (state_q != S_ERR);
    assign bus.done        = (state_q == S_DONE) || (state_q == S_ERR);
    assign bus.fault       = (state_q == S_ERR);
    assign bus.fault_cause = cause_q;
    assign bus.rdata       = rdata_q;
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Load/store sequencer between the CPU execute stage and the byte-serial `Dmemory` unit. It accepts one load/store request at a time and checks alignment and range. It drives `Dmemory`'s `start`/`wea`/`rol`/`addr`/`in_data` and holds the pipeline stalled until `busy` drops. It then returns sign- or zero-extended load data with a one-cycle `done` pulse, and a watchdog converts a hung transfer into a fault.

## Interface
- `ADDR_BITS`, default 11: byte-address width implemented by dmem; any set bit in `addr[31:ADDR_BITS]` is a range fault.
- `TIMEOUT`, default 64: maximum WAIT cycles before a timeout fault.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  1  CPU load/store request, held until `done`.
- `op`  in  3  000 LB, 001 LH, 010 LW, 011 SW, 100 LBU, 101 LHU, 110 SB, 111 SH.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `stall`  out  1  freeze CPU pipeline.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result, valid while `done`.
- `fault`  out  1  with `done`: access aborted.
- `fault_cause`  out  2  00 none, 01 misaligned, 10 range, 11 timeout.
- `mem_start`  out  1  to Dmemory `start`.
- `mem_wea`  out  1  to Dmemory `wea`.
- `mem_rol`  out  3  to Dmemory `rol`, byte count 1/2/4.
- `mem_addr`  out  32  to Dmemory `addr`.
- `mem_wdata`  out  32  to Dmemory `in_data`.
- `mem_busy`  in  1  from Dmemory `busy`.
- `mem_rdata`  in  32  from Dmemory `out_data`, right-justified.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: when `req`=1, latch `op`/`addr`/`wdata` and run checks on the latched values.
  - Misaligned if (LH/LHU/SH and `addr[0]`) or (LW/SW and `addr[1:0]`≠0).
  - Range if any of `addr[31:ADDR_BITS]`≠0.
  - Misalign has priority over range.
  - Fault → ERR; otherwise → ISSUE. Dmemory is never touched on a fault.
- ISSUE: `mem_start`=1 for exactly this cycle → WAIT, with the WAIT counter cleared.
- `mem_rol`, `mem_addr`, `mem_wdata` and `mem_wea` are driven from the latched request, stable from ISSUE through the last WAIT cycle, and 0 in all other states.
  - `mem_rol` = 1 for byte ops, 2 for half ops, 4 for word ops.
  - `mem_wea` = 1 only for SB/SH/SW.
  - `mem_wdata` = `wdata` unmodified.
- WAIT: the counter increments each cycle.
  - Exit to DONE when counter ≥1 and `mem_busy`=0. The first WAIT cycle ignores busy because busy may rise late.
  - On the same edge, capture the extended load result into the `rdata` register.
  - If the counter reaches TIMEOUT with busy still high → ERR, cause 11.
- Extension: LB sign-extends bits 7:0, LBU zero-extends 7:0, LH sign-extends 15:0, LHU zero-extends 15:0, LW passes all 32 bits. Stores return 0.
- DONE: `done`=1, `fault`=0, `stall`=0 → IDLE.
- ERR: `done`=1, `fault`=1, `fault_cause` set, `rdata`=0, `stall`=0 → IDLE.
- `stall` = `req` & (state ≠ DONE and state ≠ ERR), combinational.
- A `req` seen in the DONE/ERR cycle belongs to the already-finished instruction and is ignored. The next request is accepted from IDLE, giving one bubble per access.
- `fault_cause` holds its value until the next acceptance.

## Timing
- Reset values: state IDLE; `stall` follows `req`; `done`, `fault`, `mem_start`, `mem_wea` = 0; `fault_cause`, `rdata`, `mem_rol`, `mem_addr`, `mem_wdata` = 0; counter 0.
- Reset mid-access returns to IDLE immediately, with `mem_start`/`mem_wea` low. Dmemory shares `rst`.
- Normal access, with `req` first seen at cycle 0 and busy high over cycles 2..2+B-1 (B≥1): ISSUE at 1, WAIT 2..2+B, DONE at 3+B.
- If B=0: WAIT 2..3, DONE at 4.
- Fault access: `req` at 0, ERR at 1.
- Timeout: ERR at cycle 2+TIMEOUT.
- `rdata` changes only on WAIT exit or fault, and is otherwise held.

## Test plan
- LB at addr 0x005, byte 0x80, B=3 → `mem_start` pulse at cycle 1, `mem_rol`=1, `mem_wea`=0; `done` at 6 with `rdata`=0xFFFFFF80. LBU on the same byte → 0x00000080.
- SW at 0x010 with `wdata`=0xDEADBEEF, B=5 → `mem_wea`=1 and `mem_rol`=4 over cycles 1..7; `done` at 8, `rdata`=0; a following LW returns 0xDEADBEEF.
- LH at 0x003 → ERR at cycle 1 with `fault_cause`=01, `mem_start` never asserted. LW at 0x00000800 → `fault_cause`=10.
- `mem_busy` stuck high → `done`=1 and `fault_cause`=11 at cycle 66; `stall` drops in that same cycle.
- `rst` pulsed during WAIT → all outputs return to reset values asynchronously; a new LW after reset completes normally.
- Back-to-back: `req` held high across DONE with a new `op` → exactly one bubble, and the second access's `mem_start` arrives 2 cycles after the first `done`.
